// File: rtl/mbo_net_pkg.sv
// Shared network field widths, sentinel addresses and the peer address bundle.
// Used by the peer filter table and its per-slot storage.
package mbo_net_pkg;

    localparam int MAC_W  = 48;
    localparam int IP_W   = 32;
    localparam int PORT_W = 16;

    localparam logic [MAC_W-1:0]  MAC_UNKNOWN  = '1;
    localparam logic [MAC_W-1:0]  MAC_BCAST    = '1;
    localparam logic [IP_W-1:0]   IP_UNKNOWN   = '1;
    localparam logic [PORT_W-1:0] PORT_UNKNOWN = '1;

    typedef struct packed {
        logic [MAC_W-1:0]  mac;
        logic [IP_W-1:0]   ip;
        logic [PORT_W-1:0] port;
    } peer_addr_t;

    // MAC always compared; IP/port only when the packet carried them.
    function automatic logic peer_match(
        input peer_addr_t stored,
        input peer_addr_t seen,
        input logic       ip_vld,
        input logic       port_vld
    );
        logic mac_eq;
        logic ip_eq;
        logic port_eq;
        mac_eq  = (stored.mac == seen.mac);
        ip_eq   = !ip_vld || (stored.ip == seen.ip);
        port_eq = !port_vld || (stored.port == seen.port);
        return mac_eq && ip_eq && port_eq;
    endfunction

endpackage

// File: rtl/peer_slot.sv
// One peer table entry: stored address, valid bit, idle-age counter and
// the hit comparator against the captured source fields.
module peer_slot
    import mbo_net_pkg::*;
#(
    parameter int AGE_W   = 8,
    parameter int AGE_MAX = 255
) (
    input  logic       clock,
    input  logic       aclr,
    input  logic       flush,
    input  logic       age_tick,
    input  logic       wr_en,
    input  logic       refresh,
    input  peer_addr_t src,
    input  logic       src_ip_vld,
    input  logic       src_port_vld,
    output logic       valid,
    output logic       hit
);

    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);
    localparam logic [AGE_W-1:0] AGE_PRE = AGE_W'(AGE_MAX - 1);

    logic             valid_q;
    logic             valid_d;
    logic [AGE_W-1:0] age_q;
    logic [AGE_W-1:0] age_d;
    peer_addr_t       addr_q;
    peer_addr_t       addr_d;

    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        addr_d  = addr_q;
        if (flush) begin
            valid_d = 1'b0;
            age_d   = '0;
        end else if (wr_en) begin
            valid_d = 1'b1;
            age_d   = '0;
            addr_d  = src;
        end else if (refresh) begin
            age_d = '0;
        end else if (age_tick && valid_q) begin
            // The tick that lands on AGE_MAX also retires the entry.
            if (age_q >= AGE_PRE) begin
                age_d   = AGE_LIM;
                valid_d = 1'b0;
            end else begin
                age_d = age_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            valid_q <= 1'b0;
            age_q   <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
            addr_q  <= addr_d;
        end
    end

    assign valid = valid_q;
    assign hit   = valid_q && peer_match(addr_q, src, src_ip_vld, src_port_vld);

endmodule

// File: rtl/peer_filter_table.sv
// Board identity plus a small learned peer table; issues one accept/reject
// verdict per packet two cycles after the last active parser cycle.
module peer_filter_table
    import mbo_net_pkg::*;
#(
    parameter int NUM_PEERS = 4,
    parameter int AGE_W     = 8,
    parameter int AGE_MAX   = 255,
    parameter int IDX_W     = (NUM_PEERS > 1) ? $clog2(NUM_PEERS) : 1
) (
    input  logic                 clock,
    input  logic                 aclr,
    input  logic [MAC_W-1:0]     cfg_board_mac,
    input  logic                 cfg_board_mac_vld,
    input  logic [IP_W-1:0]      cfg_board_ip,
    input  logic                 cfg_board_ip_vld,
    input  logic                 pkt_active,
    input  logic [MAC_W-1:0]     pkt_dst_mac,
    input  logic [IP_W-1:0]      pkt_dst_ip,
    input  logic [PORT_W-1:0]    pkt_dst_port,
    input  logic [MAC_W-1:0]     pkt_src_mac,
    input  logic [IP_W-1:0]      pkt_src_ip,
    input  logic [PORT_W-1:0]    pkt_src_port,
    input  logic                 pkt_mac_vld,
    input  logic                 pkt_ip_vld,
    input  logic                 pkt_port_vld,
    input  logic                 learn_en,
    input  logic                 flush,
    input  logic                 age_tick,
    output logic                 pkt_accept,
    output logic                 pkt_reject,
    output logic [IDX_W-1:0]     peer_hit_idx,
    output logic                 learn_ovf,
    output logic [MAC_W-1:0]     board_mac,
    output logic [IP_W-1:0]      board_ip,
    output logic [PORT_W-1:0]    board_port,
    output logic [NUM_PEERS-1:0] peer_valid
);

    logic act_q;
    logic act_d;

    peer_addr_t cap_dst_q;
    peer_addr_t cap_dst_d;
    peer_addr_t cap_src_q;
    peer_addr_t cap_src_d;
    logic       cap_mac_vld_q;
    logic       cap_mac_vld_d;
    logic       cap_ip_vld_q;
    logic       cap_ip_vld_d;
    logic       cap_port_vld_q;
    logic       cap_port_vld_d;

    logic [MAC_W-1:0]  board_mac_q;
    logic [MAC_W-1:0]  board_mac_d;
    logic [IP_W-1:0]   board_ip_q;
    logic [IP_W-1:0]   board_ip_d;
    logic [PORT_W-1:0] board_port_q;
    logic [PORT_W-1:0] board_port_d;

    logic             accept_q;
    logic             accept_d;
    logic             reject_q;
    logic             reject_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    logic [NUM_PEERS-1:0] slot_valid;
    logic [NUM_PEERS-1:0] slot_hit;
    logic [NUM_PEERS-1:0] hit_oh;
    logic [NUM_PEERS-1:0] free_oh;
    logic [NUM_PEERS-1:0] wr_vec;
    logic [NUM_PEERS-1:0] refresh_vec;
    logic [IDX_W-1:0]     hit_idx;
    logic [IDX_W-1:0]     free_idx;
    logic                 any_hit;
    logic                 any_free;

    logic pkt_end;
    logic mac_ok;
    logic ip_ok;
    logic port_ok;
    logic board_ok;

    // Flags restart on the first active cycle, then accumulate.
    always_comb begin
        act_d          = pkt_active;
        cap_dst_d      = cap_dst_q;
        cap_src_d      = cap_src_q;
        cap_mac_vld_d  = cap_mac_vld_q;
        cap_ip_vld_d   = cap_ip_vld_q;
        cap_port_vld_d = cap_port_vld_q;
        if (pkt_active) begin
            cap_dst_d = '{mac: pkt_dst_mac, ip: pkt_dst_ip, port: pkt_dst_port};
            cap_src_d = '{mac: pkt_src_mac, ip: pkt_src_ip, port: pkt_src_port};
            if (!act_q) begin
                cap_mac_vld_d  = pkt_mac_vld;
                cap_ip_vld_d   = pkt_ip_vld;
                cap_port_vld_d = pkt_port_vld;
            end else begin
                cap_mac_vld_d  = cap_mac_vld_q | pkt_mac_vld;
                cap_ip_vld_d   = cap_ip_vld_q | pkt_ip_vld;
                cap_port_vld_d = cap_port_vld_q | pkt_port_vld;
            end
        end
    end

    assign pkt_end = act_q && !pkt_active;

    assign mac_ok = (cap_dst_q.mac == board_mac_q)
                 || (board_mac_q == MAC_UNKNOWN)
                 || (cap_dst_q.mac == MAC_BCAST);
    assign ip_ok = !cap_ip_vld_q
                || (cap_dst_q.ip == board_ip_q)
                || (board_ip_q == IP_UNKNOWN);
    assign port_ok = !cap_port_vld_q
                  || (cap_dst_q.port == board_port_q)
                  || (board_port_q == PORT_UNKNOWN);
    assign board_ok = mac_ok && ip_ok && port_ok;

    for (genvar g = 0; g < NUM_PEERS; g++) begin : g_slot
        peer_slot #(
            .AGE_W   (AGE_W),
            .AGE_MAX (AGE_MAX)
        ) u_slot (
            .clock        (clock),
            .aclr         (aclr),
            .flush        (flush),
            .age_tick     (age_tick),
            .wr_en        (wr_vec[g]),
            .refresh      (refresh_vec[g]),
            .src          (cap_src_q),
            .src_ip_vld   (cap_ip_vld_q),
            .src_port_vld (cap_port_vld_q),
            .valid        (slot_valid[g]),
            .hit          (slot_hit[g])
        );
    end

    // Descending scan so the lowest index is the last one written.
    always_comb begin
        any_hit  = 1'b0;
        any_free = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        hit_oh   = '0;
        free_oh  = '0;
        for (int i = NUM_PEERS - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                any_hit   = 1'b1;
                hit_idx   = IDX_W'(i);
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
            if (!slot_valid[i]) begin
                any_free   = 1'b1;
                free_idx   = IDX_W'(i);
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        accept_d     = 1'b0;
        reject_d     = 1'b0;
        ovf_d        = 1'b0;
        idx_d        = idx_q;
        wr_vec       = '0;
        refresh_vec  = '0;
        board_mac_d  = cfg_board_mac_vld ? cfg_board_mac : board_mac_q;
        board_ip_d   = cfg_board_ip_vld ? cfg_board_ip : board_ip_q;
        board_port_d = board_port_q;
        if (pkt_end) begin
            if (!cap_mac_vld_q || !board_ok) begin
                reject_d = 1'b1;
            end else if (any_hit) begin
                accept_d    = 1'b1;
                idx_d       = hit_idx;
                refresh_vec = hit_oh;
            end else if (learn_en && any_free) begin
                // A coincident flush still yields the verdict but no write.
                accept_d = 1'b1;
                idx_d    = free_idx;
                wr_vec   = flush ? '0 : free_oh;
            end else begin
                reject_d = 1'b1;
                ovf_d    = learn_en;
            end
            if (accept_d && cap_port_vld_q && board_port_q == PORT_UNKNOWN) begin
                board_port_d = cap_dst_q.port;
            end
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            act_q          <= 1'b0;
            cap_dst_q      <= '0;
            cap_src_q      <= '0;
            cap_mac_vld_q  <= 1'b0;
            cap_ip_vld_q   <= 1'b0;
            cap_port_vld_q <= 1'b0;
            board_mac_q    <= MAC_UNKNOWN;
            board_ip_q     <= IP_UNKNOWN;
            board_port_q   <= PORT_UNKNOWN;
            accept_q       <= 1'b0;
            reject_q       <= 1'b0;
            ovf_q          <= 1'b0;
            idx_q          <= '0;
        end else begin
            act_q          <= act_d;
            cap_dst_q      <= cap_dst_d;
            cap_src_q      <= cap_src_d;
            cap_mac_vld_q  <= cap_mac_vld_d;
            cap_ip_vld_q   <= cap_ip_vld_d;
            cap_port_vld_q <= cap_port_vld_d;
            board_mac_q    <= board_mac_d;
            board_ip_q     <= board_ip_d;
            board_port_q   <= board_port_d;
            accept_q       <= accept_d;
            reject_q       <= reject_d;
            ovf_q          <= ovf_d;
            idx_q          <= idx_d;
        end
    end

    assign pkt_accept   = accept_q;
    assign pkt_reject   = reject_q;
    assign learn_ovf    = ovf_q;
    assign peer_hit_idx = idx_q;
    assign board_mac    = board_mac_q;
    assign board_ip     = board_ip_q;
    assign board_port   = board_port_q;
    assign peer_valid   = slot_valid;

endmodule

// File: tb/tb_peer_filter_table.sv
// Directed bench for peer_filter_table: learning, overflow, matching rules,
// aging, flush and reset behaviour with hand-computed expectations.
module tb_peer_filter_table;

    localparam logic [47:0] BMAC  = 48'h02_11_22_33_44_55;
    localparam logic [31:0] BIP   = 32'hC0A8_0001;
    localparam logic [15:0] BPORT = 16'd7000;
    localparam logic [31:0] PIP   = 32'h0A00_0001;
    localparam logic [15:0] PPORT = 16'd5000;
    localparam logic [47:0] PM0   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] PM1   = 48'h02_00_00_00_00_02;
    localparam logic [47:0] PM2   = 48'h02_00_00_00_00_03;
    localparam logic [47:0] PM3   = 48'h02_00_00_00_00_04;
    localparam logic [47:0] PM4   = 48'h02_00_00_00_00_05;
    localparam logic [47:0] PM5   = 48'h02_00_00_00_00_06;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] OTHER = 48'h02_AA_AA_AA_AA_AA;

    logic        clock = 1'b0;
    logic        aclr = 1'b0;
    logic [47:0] cfg_board_mac = '0;
    logic        cfg_board_mac_vld = 1'b0;
    logic [31:0] cfg_board_ip = '0;
    logic        cfg_board_ip_vld = 1'b0;
    logic        pkt_active = 1'b0;
    logic [47:0] pkt_dst_mac = '0;
    logic [31:0] pkt_dst_ip = '0;
    logic [15:0] pkt_dst_port = '0;
    logic [47:0] pkt_src_mac = '0;
    logic [31:0] pkt_src_ip = '0;
    logic [15:0] pkt_src_port = '0;
    logic        pkt_mac_vld = 1'b0;
    logic        pkt_ip_vld = 1'b0;
    logic        pkt_port_vld = 1'b0;
    logic        learn_en = 1'b0;
    logic        flush = 1'b0;
    logic        age_tick = 1'b0;
    logic        pkt_accept;
    logic        pkt_reject;
    logic [1:0]  peer_hit_idx;
    logic        learn_ovf;
    logic [47:0] board_mac;
    logic [31:0] board_ip;
    logic [15:0] board_port;
    logic [3:0]  peer_valid;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    peer_filter_table #(
        .NUM_PEERS (4),
        .AGE_W     (8),
        .AGE_MAX   (3)
    ) dut (
        .clock             (clock),
        .aclr              (aclr),
        .cfg_board_mac     (cfg_board_mac),
        .cfg_board_mac_vld (cfg_board_mac_vld),
        .cfg_board_ip      (cfg_board_ip),
        .cfg_board_ip_vld  (cfg_board_ip_vld),
        .pkt_active        (pkt_active),
        .pkt_dst_mac       (pkt_dst_mac),
        .pkt_dst_ip        (pkt_dst_ip),
        .pkt_dst_port      (pkt_dst_port),
        .pkt_src_mac       (pkt_src_mac),
        .pkt_src_ip        (pkt_src_ip),
        .pkt_src_port      (pkt_src_port),
        .pkt_mac_vld       (pkt_mac_vld),
        .pkt_ip_vld        (pkt_ip_vld),
        .pkt_port_vld      (pkt_port_vld),
        .learn_en          (learn_en),
        .flush             (flush),
        .age_tick          (age_tick),
        .pkt_accept        (pkt_accept),
        .pkt_reject        (pkt_reject),
        .peer_hit_idx      (peer_hit_idx),
        .learn_ovf         (learn_ovf),
        .board_mac         (board_mac),
        .board_ip          (board_ip),
        .board_port        (board_port),
        .peer_valid        (peer_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_verdict(input string tag, input logic acc, input logic rej,
                               input logic ovf);
        chk({tag, ".accept"}, {63'd0, pkt_accept}, {63'd0, acc});
        chk({tag, ".reject"}, {63'd0, pkt_reject}, {63'd0, rej});
        chk({tag, ".ovf"}, {63'd0, learn_ovf}, {63'd0, ovf});
    endtask

    // One active cycle, then the end cycle; returns in the verdict cycle.
    task automatic send_pkt(
        input logic [47:0] dm, input logic [31:0] di, input logic [15:0] dp,
        input logic [47:0] sm, input logic [31:0] si, input logic [15:0] sp,
        input logic mv, input logic iv, input logic pv,
        input logic e_flush, input logic e_tick
    );
        @(posedge clock); #1;
        pkt_active   = 1'b1;
        pkt_dst_mac  = dm;
        pkt_dst_ip   = di;
        pkt_dst_port = dp;
        pkt_src_mac  = sm;
        pkt_src_ip   = si;
        pkt_src_port = sp;
        pkt_mac_vld  = mv;
        pkt_ip_vld   = iv;
        pkt_port_vld = pv;
        @(posedge clock); #1;
        pkt_active   = 1'b0;
        pkt_mac_vld  = 1'b0;
        pkt_ip_vld   = 1'b0;
        pkt_port_vld = 1'b0;
        flush        = e_flush;
        age_tick     = e_tick;
        @(posedge clock); #1;
        flush    = 1'b0;
        age_tick = 1'b0;
    endtask

    task automatic peer_pkt(input logic [47:0] sm, input logic [15:0] sp, input logic pv);
        send_pkt(BMAC, BIP, BPORT, sm, PIP, sp, 1'b1, 1'b1, pv, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock); #1;
        age_tick = 1'b1;
        @(posedge clock); #1;
        age_tick = 1'b0;
    endtask

    initial begin
        aclr = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst.board_mac", {16'd0, board_mac}, {16'd0, 48'hFFFF_FFFF_FFFF});
        chk("rst.board_ip", {32'd0, board_ip}, 64'h0000_0000_FFFF_FFFF);
        chk("rst.board_port", {48'd0, board_port}, 64'h0000_0000_0000_FFFF);
        chk("rst.peer_valid", {60'd0, peer_valid}, 64'd0);
        chk("rst.idx", {62'd0, peer_hit_idx}, 64'd0);
        chk_verdict("rst", 1'b0, 1'b0, 1'b0);
        aclr = 1'b0;

        @(posedge clock); #1;
        cfg_board_mac     = BMAC;
        cfg_board_mac_vld = 1'b1;
        cfg_board_ip      = BIP;
        cfg_board_ip_vld  = 1'b1;
        @(posedge clock); #1;
        cfg_board_mac_vld = 1'b0;
        cfg_board_ip_vld  = 1'b0;
        chk("cfg.board_mac", {16'd0, board_mac}, {16'd0, BMAC});
        chk("cfg.board_ip", {32'd0, board_ip}, {32'd0, BIP});

        learn_en = 1'b1;
        peer_pkt(PM0, PPORT, 1'b1);
        chk_verdict("learn0", 1'b1, 1'b0, 1'b0);
        chk("learn0.idx", {62'd0, peer_hit_idx}, 64'd0);
        chk("learn0.valid", {60'd0, peer_valid}, 64'b0001);
        chk("learn0.board_port", {48'd0, board_port}, {48'd0, BPORT});
        @(posedge clock); #1;
        chk("learn0.pulse_end", {63'd0, pkt_accept}, 64'd0);

        peer_pkt(PM1, PPORT, 1'b1);
        chk("learn1.idx", {62'd0, peer_hit_idx}, 64'd1);
        peer_pkt(PM2, PPORT, 1'b1);
        chk("learn2.idx", {62'd0, peer_hit_idx}, 64'd2);
        peer_pkt(PM3, PPORT, 1'b1);
        chk_verdict("learn3", 1'b1, 1'b0, 1'b0);
        chk("learn3.idx", {62'd0, peer_hit_idx}, 64'd3);
        chk("learn3.valid", {60'd0, peer_valid}, 64'b1111);

        peer_pkt(PM4, PPORT, 1'b1);
        chk_verdict("full", 1'b0, 1'b1, 1'b1);
        chk("full.valid", {60'd0, peer_valid}, 64'b1111);

        peer_pkt(PM0, 16'd5001, 1'b1);
        chk_verdict("badport", 1'b0, 1'b1, 1'b1);
        peer_pkt(PM0, 16'd5001, 1'b0);
        chk_verdict("noport", 1'b1, 1'b0, 1'b0);
        chk("noport.idx", {62'd0, peer_hit_idx}, 64'd0);

        send_pkt(BCAST, BIP, BPORT, PM1, PIP, PPORT, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_verdict("bcast", 1'b1, 1'b0, 1'b0);
        chk("bcast.idx", {62'd0, peer_hit_idx}, 64'd1);

        send_pkt(OTHER, BIP, BPORT, PM2, PIP, PPORT, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_verdict("ucast_other", 1'b0, 1'b1, 1'b0);
        chk("ucast_other.valid", {60'd0, peer_valid}, 64'b1111);

        send_pkt(BMAC, BIP, BPORT, PM0, PIP, PPORT, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_verdict("no_mac_vld", 1'b0, 1'b1, 1'b0);

        @(posedge clock); #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        chk("flush.valid", {60'd0, peer_valid}, 64'd0);
        peer_pkt(PM0, PPORT, 1'b1);
        chk("relearn.valid", {60'd0, peer_valid}, 64'b0001);
        send_pkt(BMAC, BIP, BPORT, PM5, PIP, PPORT, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_verdict("flush_e", 1'b1, 1'b0, 1'b0);
        chk("flush_e.idx", {62'd0, peer_hit_idx}, 64'd1);
        chk("flush_e.valid", {60'd0, peer_valid}, 64'd0);

        peer_pkt(PM0, PPORT, 1'b1);
        chk("age.learn", {60'd0, peer_valid}, 64'b0001);
        tick();
        tick();
        chk("age.two_ticks", {60'd0, peer_valid}, 64'b0001);
        tick();
        chk("age.expired", {60'd0, peer_valid}, 64'd0);

        peer_pkt(PM0, PPORT, 1'b1);
        tick();
        tick();
        send_pkt(BMAC, BIP, BPORT, PM0, PIP, PPORT, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk_verdict("hit_tick", 1'b1, 1'b0, 1'b0);
        chk("hit_tick.valid", {60'd0, peer_valid}, 64'b0001);
        tick();
        tick();
        chk("hit_tick.two_more", {60'd0, peer_valid}, 64'b0001);
        tick();
        chk("hit_tick.expired", {60'd0, peer_valid}, 64'd0);

        learn_en = 1'b0;
        peer_pkt(PM0, PPORT, 1'b1);
        chk_verdict("no_learn", 1'b0, 1'b1, 1'b0);
        chk("no_learn.valid", {60'd0, peer_valid}, 64'd0);
        learn_en = 1'b1;

        @(posedge clock); #1;
        pkt_active   = 1'b1;
        pkt_dst_mac  = BMAC;
        pkt_src_mac  = PM0;
        pkt_mac_vld  = 1'b1;
        @(posedge clock); #1;
        aclr = 1'b1;
        @(posedge clock); #1;
        aclr        = 1'b0;
        pkt_active  = 1'b0;
        pkt_mac_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("aclr.no_verdict", {62'd0, pkt_accept, pkt_reject}, 64'd0);
        end
        chk("aclr.board_mac", {16'd0, board_mac}, {16'd0, 48'hFFFF_FFFF_FFFF});
        chk("aclr.board_ip", {32'd0, board_ip}, 64'h0000_0000_FFFF_FFFF);
        chk("aclr.board_port", {48'd0, board_port}, 64'h0000_0000_0000_FFFF);
        chk("aclr.valid", {60'd0, peer_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
